// File: rtl/serial_frame_rx_if.sv
// rtl/serial_frame_rx_if.sv - bit-serial strobe/data and frame status bundle for serial_frame_rx
interface serial_frame_rx_if #(
    parameter int LEN_W = 4
);
    logic             clk_en;
    logic             ser_in;
    logic             ser_out;
    logic             ser_out_valid;
    logic             sync_found;
    logic             frame_done;
    logic             busy;
    logic [LEN_W-1:0] frame_len;
    logic [LEN_W-1:0] bit_cnt;

    // Line sampler side: supplies the bit strobe and serial data, observes frame status
    modport master (
        output clk_en,
        output ser_in,
        input  ser_out,
        input  ser_out_valid,
        input  sync_found,
        input  frame_done,
        input  busy,
        input  frame_len,
        input  bit_cnt
    );

    // Receiver side
    modport slave (
        input  clk_en,
        input  ser_in,
        output ser_out,
        output ser_out_valid,
        output sync_found,
        output frame_done,
        output busy,
        output frame_len,
        output bit_cnt
    );
endinterface

// File: rtl/serial_frame_rx.sv
// rtl/serial_frame_rx.sv - sync-pattern hunting serial frame receiver with serial length field
module serial_frame_rx #(
    parameter int               PAT_W   = 6,
    parameter logic [PAT_W-1:0] PATTERN = 6'b110101,
    parameter int               LEN_W   = 4
) (
    input  logic               clk,
    input  logic               rst,
    serial_frame_rx_if.slave   bus
);

    localparam int FILL_W = $clog2(PAT_W + 1);
    localparam int IDX_W  = (LEN_W > 1) ? $clog2(LEN_W) : 1;

    typedef enum logic [1:0] {
        HUNT = 2'd0,
        LEN  = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t             state;
    // Only the previous PAT_W-1 bits are kept: together with the incoming
    // bit they form the full comparison window.
    logic [PAT_W-2:0]   sr;
    logic [FILL_W-1:0]  fill;
    logic [LEN_W-2:0]   len_sr;
    logic [IDX_W-1:0]   len_idx;
    logic [LEN_W-1:0]   frame_len_q;
    logic [LEN_W-1:0]   bit_cnt_q;
    logic               sync_q;

    logic [PAT_W-1:0]   window;
    logic               match;
    logic [LEN_W-1:0]   len_word;

    // Candidate pattern window and length word including the bit on the line now
    always_comb begin
        window   = {sr, bus.ser_in};
        len_word = {len_sr, bus.ser_in};
        match    = (window == PATTERN) && (fill >= FILL_W'(PAT_W - 1));
    end

    // Frame FSM: hunt, shift in length, count payload, one-cycle done
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= HUNT;
            sr          <= '0;
            fill        <= '0;
            len_sr      <= '0;
            len_idx     <= '0;
            frame_len_q <= '0;
            bit_cnt_q   <= '0;
            sync_q      <= 1'b0;
        end else begin
            sync_q <= 1'b0;
            case (state)
                HUNT: begin
                    if (bus.clk_en) begin
                        sr <= window[PAT_W-2:0];
                        if (fill != FILL_W'(PAT_W)) begin
                            fill <= fill + FILL_W'(1);
                        end
                        if (match) begin
                            state   <= LEN;
                            len_idx <= '0;
                            sync_q  <= 1'b1;
                        end
                    end
                end
                LEN: begin
                    if (bus.clk_en) begin
                        len_sr <= len_word[LEN_W-2:0];
                        if (len_idx == IDX_W'(LEN_W - 1)) begin
                            frame_len_q <= len_word;
                            bit_cnt_q   <= '0;
                            state       <= (len_word == '0) ? DONE : DATA;
                        end else begin
                            len_idx <= len_idx + IDX_W'(1);
                        end
                    end
                end
                DATA: begin
                    if (bus.clk_en) begin
                        bit_cnt_q <= bit_cnt_q + LEN_W'(1);
                        if (bit_cnt_q == frame_len_q - LEN_W'(1)) begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    // Payload must never contribute to the next sync search
                    sr    <= '0;
                    fill  <= '0;
                    state <= HUNT;
                end
                default: state <= HUNT;
            endcase
        end
    end

    // Pass-through data and status decode
    assign bus.ser_out       = bus.ser_in;
    assign bus.ser_out_valid = (state == DATA) && bus.clk_en;
    assign bus.sync_found    = sync_q;
    assign bus.frame_done    = (state == DONE);
    assign bus.busy          = (state != HUNT);
    assign bus.frame_len     = frame_len_q;
    assign bus.bit_cnt       = bit_cnt_q;

endmodule
